if_id_latch: RTL
================

Name: if_id_latch

Overview:
- IF/ID pipeline register of the 5-stage MIPS core.
- Captures the fetched instruction and PC+4 from the fetch stage and splits the instruction into decode fields.
- Drives the 16-bit immediate and extension-mode select straight into the sign-extension unit, and rs/rt indices into the register file.
- Handles load-use stall, branch/jump flush and HALT detection with a small run/halt state machine.

Parameters:
- NB_DATA, 32, instruction and PC width
- NB_IMM, 16, immediate field width fed to the extender
- NB_REG, 5, register index width
- HALT_OPCODE, 32'hFFFF_FFFF, instruction word that stops the pipeline

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  asynchronous active-low reset
- i_Enable  in  1  global pipeline enable (debug unit); 0 freezes all state
- i_Instr  in  NB_DATA  instruction from instruction memory
- i_PC4  in  NB_DATA  PC+4 from fetch
- i_Stall  in  1  hazard unit: hold current contents
- i_Flush  in  1  branch/jump taken: replace contents with bubble
- o_Instr  out  NB_DATA  latched instruction
- o_PC4  out  NB_DATA  latched PC+4
- o_Valid  out  1  latched instruction is real, not a bubble
- o_Opcode  out  6  instr[31:26]
- o_Rs, o_Rt, o_Rd  out  NB_REG each  instr[25:21], [20:16], [15:11]
- o_Shamt  out  5  instr[10:6]
- o_Funct  out  6  instr[5:0]
- o_Imm  out  NB_IMM  instr[15:0], to extender i_signal
- o_ExtensionMode  out  2  00 sign, 01 zero (ANDI/ORI/XORI), 10 upper (LUI), 11 for bubble
- o_Halt  out  1  HALT instruction reached ID; pipeline stopped

Behaviour:
- Reset (i_reset=0, async): o_Instr=0, o_PC4=0, o_Valid=0, o_Halt=0, state RUN. All field outputs derive from o_Instr=0; o_ExtensionMode=2'b11 while o_Valid=0.
- Field outputs and o_ExtensionMode are combinational from the registered instruction; they have no added latency.
- Register update on rising i_clk, priority in this order:
  1. i_Enable=0: hold everything.
  2. state HALTED: hold everything.
  3. i_Flush=1: o_Instr←0 (NOP), o_Valid←0, o_PC4 holds. Flush wins over stall when both are asserted.
  4. i_Stall=1: hold o_Instr, o_PC4 and o_Valid.
  5. Otherwise: o_Instr←i_Instr, o_PC4←i_PC4, o_Valid←1.
- Latency: one cycle from fetch inputs to outputs.
- Extension-mode decode (opcode):
  - 001100, 001101, 001110 → 01
  - 001111 → 10
  - all other opcodes → 00
  - o_Valid=0 → 11 (extender outputs all ones; consumers ignore it).
- State machine:
  - RUN → HALTED on the edge that loads i_Instr==HALT_OPCODE through path 5. o_Halt=1 from that cycle on.
  - HALTED is sticky until reset. Stall and flush are ignored while HALTED.
  - A HALT word arriving with i_Flush=1 is discarded; no halt.
  - A HALT word presented while i_Stall=1 is not loaded; no halt until it is actually loaded.
- Reset asserted mid-stall or while HALTED returns to the reset values immediately.

Optional Feature:
- Macro IF_ID_PERF_CNT_EN.
- When defined, adds two outputs:
  - o_StallCnt[31:0]: increments on each enabled RUN cycle with i_Stall=1 and i_Flush=0.
  - o_FlushCnt[31:0]: increments on each enabled RUN cycle with i_Flush=1.
  - Both counters reset to 0, wrap at 2^32, and freeze while HALTED or i_Enable=0.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset then load i_Instr=32'h2128_FFFF (ADDI), i_PC4=4 → next cycle: o_Valid=1, o_Rs=9, o_Rt=8, o_Imm=16'hFFFF, o_ExtensionMode=00, o_PC4=4.
- Load 32'h3C01_1234 (LUI) → o_ExtensionMode=10, o_Imm=16'h1234. Load 32'h3421_00FF (ORI) → o_ExtensionMode=01.
- i_Stall=1 for 3 cycles while i_Instr changes → o_Instr and o_PC4 unchanged; with the macro enabled, o_StallCnt=3.
- i_Stall=1 and i_Flush=1 together → o_Instr=0, o_Valid=0, o_ExtensionMode=11, o_PC4 held.
- Load 32'hFFFF_FFFF → o_Halt=1; later i_Instr/i_Flush activity has no effect. Pulse i_reset low → o_Halt=0, o_Valid=0.
- i_Enable=0 with new i_Instr and i_Flush=1 → all outputs hold. i_reset low asynchronously mid-cycle → outputs clear before the next clock edge.

Source files
------------

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: latches fetch outputs, splits decode fields, handles stall/flush/halt.
// Optional stall/flush performance counters are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_latch #(
    parameter int unsigned        NB_DATA     = 32,
    parameter int unsigned        NB_IMM      = 16,
    parameter int unsigned        NB_REG      = 5,
    parameter logic [NB_DATA-1:0] HALT_OPCODE = 32'hFFFF_FFFF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_Enable,
    input  logic [NB_DATA-1:0] i_Instr,
    input  logic [NB_DATA-1:0] i_PC4,
    input  logic               i_Stall,
    input  logic               i_Flush,
    output logic [NB_DATA-1:0] o_Instr,
    output logic [NB_DATA-1:0] o_PC4,
    output logic               o_Valid,
    output logic [5:0]         o_Opcode,
    output logic [NB_REG-1:0]  o_Rs,
    output logic [NB_REG-1:0]  o_Rt,
    output logic [NB_REG-1:0]  o_Rd,
    output logic [4:0]         o_Shamt,
    output logic [5:0]         o_Funct,
    output logic [NB_IMM-1:0]  o_Imm,
    output logic [1:0]         o_ExtensionMode,
    output logic               o_Halt
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]        o_StallCnt,
    output logic [31:0]        o_FlushCnt
`endif
);

    typedef enum logic {StRun, StHalted} state_e;

    localparam logic [5:0] OpAndi = 6'b001100;
    localparam logic [5:0] OpOri  = 6'b001101;
    localparam logic [5:0] OpXori = 6'b001110;
    localparam logic [5:0] OpLui  = 6'b001111;

    state_e             state_q;
    logic [NB_DATA-1:0] instr_q;
    logic [NB_DATA-1:0] pc4_q;
    logic               valid_q;
    logic               run_en;

    assign run_en = i_Enable && (state_q == StRun);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StRun;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (run_en) begin
            if (i_Flush) begin
                // Bubble: NOP word, PC+4 kept for debug visibility
                instr_q <= '0;
                valid_q <= 1'b0;
            end else if (!i_Stall) begin
                instr_q <= i_Instr;
                pc4_q   <= i_PC4;
                valid_q <= 1'b1;
                if (i_Instr == HALT_OPCODE) begin
                    state_q <= StHalted;
                end
            end
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (run_en) begin
            if (i_Flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end else if (i_Stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign o_StallCnt = stall_cnt_q;
    assign o_FlushCnt = flush_cnt_q;
`endif

    assign o_Instr  = instr_q;
    assign o_PC4    = pc4_q;
    assign o_Valid  = valid_q;
    assign o_Halt   = (state_q == StHalted);
    assign o_Opcode = instr_q[31:26];
    assign o_Rs     = instr_q[25:21];
    assign o_Rt     = instr_q[20:16];
    assign o_Rd     = instr_q[15:11];
    assign o_Shamt  = instr_q[10:6];
    assign o_Funct  = instr_q[5:0];
    assign o_Imm    = instr_q[NB_IMM-1:0];

    always_comb begin
        o_ExtensionMode = 2'b00;
        if (!valid_q) begin
            o_ExtensionMode = 2'b11;
        end else begin
            case (instr_q[31:26])
                OpAndi, OpOri, OpXori: o_ExtensionMode = 2'b01;
                OpLui:                 o_ExtensionMode = 2'b10;
                default:               o_ExtensionMode = 2'b00;
            endcase
        end
    end

endmodule
